// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad number-entry block: key codes, entry states,
// auto-repeat timing (used only with KEYPAD_AUTOREPEAT_EN) and the keymap decode.
package keypad_pkg;

   localparam logic [3:0] KEY_A = 4'hA;
   localparam logic [3:0] KEY_B = 4'hB;
   localparam logic [3:0] KEY_C = 4'hC;
   localparam logic [3:0] KEY_D = 4'hD;
   localparam logic [3:0] KEY_E = 4'hE;
   localparam logic [3:0] KEY_F = 4'hF;

   localparam int REPEAT_FIRST = 500;
   localparam int REPEAT_NEXT  = 100;

   typedef enum logic [0:0] {
      ST_ENTRY   = 1'b0,
      ST_ENTERED = 1'b1
   } state_e;

   // Nibble i holds the code of raw bit i = row*4 + col.
   localparam logic [63:0] KEYMAP_TABLE = 64'hDF0E_C987_B654_A321;

   function automatic logic [3:0] keymap(input logic [15:0] bitmap);
      logic [3:0] code;
      code = 4'h0;
      for (int i = 0; i < 16; i++) begin
         code = code | (bitmap[i] ? KEYMAP_TABLE[i*4 +: 4] : 4'h0);
      end
      return code;
   endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column drive, row sampling and full-scan debounce for a 4x4 active-low keypad.
// Exposes scan_done_o only when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 20
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [3:0]  row_i,
   output logic [3:0]  col_o,
   output logic [15:0] accepted_o,
`ifdef KEYPAD_AUTOREPEAT_EN
   output logic        scan_done_o,
`endif
   output logic        accept_o
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);

   logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [3:0]       col_q, col_d;
   logic [15:0]      raw_q, raw_d;
   logic [15:0]      prev_q, prev_d;
   logic [15:0]      acc_q, acc_d;
   logic [STB_W-1:0] stable_q, stable_d;
   logic             accept_q, accept_d;
   logic             sample_s;
`ifdef KEYPAD_AUTOREPEAT_EN
   logic             scan_done_q, scan_done_d;
`endif

   // Divider, column rotation, inverted row capture and debounce of each completed scan.
   always_comb begin
      scan_cnt_d = scan_cnt_q;
      col_idx_d  = col_idx_q;
      col_d      = col_q;
      raw_d      = raw_q;
      prev_d     = prev_q;
      stable_d   = stable_q;
      acc_d      = acc_q;
      accept_d   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      scan_done_d = 1'b0;
`endif
      sample_s   = (scan_cnt_q == CNT_LAST);

      if (sample_s) begin
         scan_cnt_d = {CNT_W{1'b0}};
         col_idx_d  = col_idx_q + 2'd1;
         col_d      = ~(4'b0001 << col_idx_d);
         for (int r = 0; r < 4; r++) begin
            raw_d[{2'(r), col_idx_q}] = ~row_i[r];
         end
      end else begin
         scan_cnt_d = scan_cnt_q + CNT_W'(1);
      end

      // raw_d already holds column 3 here, so the comparison sees the whole scan.
      if (sample_s && (col_idx_q == 2'd3)) begin
`ifdef KEYPAD_AUTOREPEAT_EN
         scan_done_d = 1'b1;
`endif
         prev_d = raw_d;
         if (raw_d == prev_q) begin
            if (stable_q != STB_MAX) begin
               stable_d = stable_q + STB_W'(1);
            end else begin
               stable_d = stable_q;
            end
         end else begin
            stable_d = {STB_W{1'b0}};
         end
         if ((stable_d == STB_MAX) && (raw_d != acc_q)) begin
            acc_d    = raw_d;
            accept_d = 1'b1;
         end else begin
            acc_d    = acc_q;
            accept_d = 1'b0;
         end
      end else begin
         prev_d = prev_q;
      end
   end

   // Scanner state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scan_cnt_q <= {CNT_W{1'b0}};
         col_idx_q  <= 2'd0;
         col_q      <= 4'b1110;
         raw_q      <= 16'h0000;
         prev_q     <= 16'h0000;
         acc_q      <= 16'h0000;
         stable_q   <= {STB_W{1'b0}};
         accept_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         scan_done_q <= 1'b0;
`endif
      end else begin
         scan_cnt_q <= scan_cnt_d;
         col_idx_q  <= col_idx_d;
         col_q      <= col_d;
         raw_q      <= raw_d;
         prev_q     <= prev_d;
         acc_q      <= acc_d;
         stable_q   <= stable_d;
         accept_q   <= accept_d;
`ifdef KEYPAD_AUTOREPEAT_EN
         scan_done_q <= scan_done_d;
`endif
      end
   end

   assign col_o      = col_q;
   assign accepted_o = acc_q;
   assign accept_o   = accept_q;
`ifdef KEYPAD_AUTOREPEAT_EN
   assign scan_done_o = scan_done_q;
`endif

endmodule

// File: rtl/keypad_number_entry.sv
// 4x4 keypad number entry: decodes debounced presses and accumulates up to four
// decimal digits. Defining KEYPAD_AUTOREPEAT_EN adds auto-repeat for digits and backspace.
module keypad_number_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 20
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [3:0]  Row,
   output logic [3:0]  Col,
   output logic [15:0] Number,
   output logic        NumberValid,
   output logic [3:0]  KeyCode,
   output logic        KeyStrobe,
   output logic [2:0]  DigitCount
);

   logic [15:0] accepted_s;
   logic        accept_s;
   logic        single_s;
   logic        press_s;
   logic        repeat_s;
   logic        event_s;
   logic [3:0]  key_s;

   state_e      state_q, state_d;
   logic [13:0] num_q, num_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [3:0]  code_q, code_d;
   logic        strobe_q, strobe_d;
   logic        valid_q, valid_d;
   logic [15:0] acc_prev_q;

`ifdef KEYPAD_AUTOREPEAT_EN
   logic        scan_done_s;
`endif

   keypad_scanner #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) u_scanner (
      .clk_i       (Clk),
      .rst_i       (Rst),
      .row_i       (Row),
      .col_o       (Col),
      .accepted_o  (accepted_s),
`ifdef KEYPAD_AUTOREPEAT_EN
      .scan_done_o (scan_done_s),
`endif
      .accept_o    (accept_s)
   );

   // A press is a transition from nothing held to exactly one key held.
   assign single_s = (accepted_s != 16'h0000) &&
                     ((accepted_s & (accepted_s - 16'd1)) == 16'h0000);
   assign press_s  = accept_s && single_s && (acc_prev_q == 16'h0000);
   assign key_s    = keymap(accepted_s);
   assign event_s  = press_s | repeat_s;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int REP_W = $clog2(REPEAT_FIRST + 1);

   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [REP_W-1:0] rep_limit_s;
   logic             rep_first_q, rep_first_d;
   logic             rep_arm_q, rep_arm_d;
   logic             repeatable_s;

   assign repeatable_s = (key_s <= 4'd9) || (key_s == KEY_B);
   assign rep_limit_s  = rep_first_q ? REP_W'(REPEAT_FIRST) : REP_W'(REPEAT_NEXT);

   // Counts full scans while a pressed key stays held; any bitmap change restarts it.
   always_comb begin
      rep_cnt_d   = rep_cnt_q;
      rep_first_d = rep_first_q;
      rep_arm_d   = rep_arm_q;
      repeat_s    = 1'b0;
      if (accept_s) begin
         rep_cnt_d   = {REP_W{1'b0}};
         rep_first_d = 1'b1;
         rep_arm_d   = press_s;
      end else if (rep_arm_q && scan_done_s) begin
         if ((rep_cnt_q + REP_W'(1)) == rep_limit_s) begin
            rep_cnt_d   = {REP_W{1'b0}};
            rep_first_d = 1'b0;
            repeat_s    = repeatable_s;
         end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
         end
      end else begin
         repeat_s = 1'b0;
      end
   end

   // Auto-repeat registers.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         rep_cnt_q   <= {REP_W{1'b0}};
         rep_first_q <= 1'b1;
         rep_arm_q   <= 1'b0;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_first_q <= rep_first_d;
         rep_arm_q   <= rep_arm_d;
      end
   end
`else
   assign repeat_s = 1'b0;
`endif

   // Key actions: digit accumulation, enter, backspace and clear.
   always_comb begin
      state_d  = state_q;
      num_d    = num_q;
      cnt_d    = cnt_q;
      code_d   = code_q;
      strobe_d = 1'b0;
      valid_d  = 1'b0;
      if (event_s) begin
         strobe_d = 1'b1;
         code_d   = key_s;
         if (key_s <= 4'd9) begin
            if (state_q == ST_ENTERED) begin
               num_d   = {10'd0, key_s};
               cnt_d   = 3'd1;
               state_d = ST_ENTRY;
            end else if (cnt_q < 3'd4) begin
               num_d = (num_q * 14'd10) + {10'd0, key_s};
               cnt_d = cnt_q + 3'd1;
            end else begin
               num_d = num_q;
            end
         end else begin
            case (key_s)
               KEY_A: begin
                  valid_d = 1'b1;
                  state_d = ST_ENTERED;
               end
               KEY_B: begin
                  state_d = ST_ENTRY;
                  if (cnt_q != 3'd0) begin
                     num_d = num_q / 14'd10;
                     cnt_d = cnt_q - 3'd1;
                  end else begin
                     num_d = num_q;
                  end
               end
               KEY_C: begin
                  num_d   = 14'd0;
                  cnt_d   = 3'd0;
                  state_d = ST_ENTRY;
               end
               KEY_D, KEY_E, KEY_F: begin
                  state_d = state_q;
               end
               default: begin
                  state_d = state_q;
               end
            endcase
         end
      end else begin
         strobe_d = 1'b0;
      end
   end

   // Entry state and registered outputs.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= ST_ENTRY;
         num_q      <= 14'd0;
         cnt_q      <= 3'd0;
         code_q     <= 4'h0;
         strobe_q   <= 1'b0;
         valid_q    <= 1'b0;
         acc_prev_q <= 16'h0000;
      end else begin
         state_q    <= state_d;
         num_q      <= num_d;
         cnt_q      <= cnt_d;
         code_q     <= code_d;
         strobe_q   <= strobe_d;
         valid_q    <= valid_d;
         acc_prev_q <= accepted_s;
      end
   end

   assign Number      = {2'b00, num_q};
   assign NumberValid = valid_q;
   assign KeyCode     = code_q;
   assign KeyStrobe   = strobe_q;
   assign DigitCount  = cnt_q;

endmodule
